// File: rtl/decode_pkg.sv
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared types and field-offset helpers for the decode stage.
//                Holds the stage state encoding, the default load opcode
//                and functions that locate each instruction field from the
//                configured widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    // Occupancy of the two-entry stage (output register + skid entry)
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    // Opcode the interlock treats as a load unless overridden
    localparam logic [3:0] c_LOAD_OP_DEFAULT = 4'h8;

    // Lowest bit of the opcode field (opcode sits at the top of the word)
    function automatic int opc_lsb(input int inst_w, input int opc_w);
        return inst_w - opc_w;
    endfunction

    // Lowest bit of the destination register field, directly below opcode
    function automatic int rd_lsb(input int inst_w, input int opc_w, input int reg_aw);
        return inst_w - opc_w - reg_aw;
    endfunction

    // Lowest bit of the first source register field
    function automatic int ra_lsb(input int inst_w, input int opc_w, input int reg_aw);
        return inst_w - opc_w - 2 * reg_aw;
    endfunction

    // Lowest bit of the second source register field, directly above func
    function automatic int rb_lsb(input int inst_w, input int opc_w, input int reg_aw);
        return inst_w - opc_w - 3 * reg_aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_fields.sv
// ============================================================================
//  Module      : decode_fields
//  Description : Purely combinational split of an instruction word into
//                opcode, register addresses and function code, plus the
//                sign-extended immediate ({rd, func}) and jump address.
//                A field wider than DATA_W keeps only its low DATA_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_fields
    import decode_pkg::*;
#(
    parameter int INST_W  = 16,
    parameter int OPC_W   = 4,
    parameter int REG_AW  = 3,
    parameter int FUNC_W  = 3,
    parameter int DATA_W  = 8,
    parameter int ADDR_FW = 7
) (
    input  logic [INST_W-1:0] i_inst,
    output logic [OPC_W-1:0]  o_opcode,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic [REG_AW-1:0] o_ra_addr,
    output logic [REG_AW-1:0] o_rb_addr,
    output logic [FUNC_W-1:0] o_func,
    output logic [DATA_W-1:0] o_imm,
    output logic [DATA_W-1:0] o_addr
);

    localparam int c_OPC_LSB = opc_lsb(INST_W, OPC_W);
    localparam int c_RD_LSB  = rd_lsb(INST_W, OPC_W, REG_AW);
    localparam int c_RA_LSB  = ra_lsb(INST_W, OPC_W, REG_AW);
    localparam int c_RB_LSB  = rb_lsb(INST_W, OPC_W, REG_AW);
    localparam int c_IMM_W   = REG_AW + FUNC_W;

    logic [c_IMM_W-1:0] w_imm_raw;
    logic [ADDR_FW-1:0] w_addr_raw;

    assign o_opcode  = i_inst[c_OPC_LSB +: OPC_W];
    assign o_rd_addr = i_inst[c_RD_LSB +: REG_AW];
    assign o_ra_addr = i_inst[c_RA_LSB +: REG_AW];
    assign o_rb_addr = i_inst[c_RB_LSB +: REG_AW];
    assign o_func    = i_inst[FUNC_W-1:0];

    // The immediate is the destination field glued onto the function code
    assign w_imm_raw  = {i_inst[c_RD_LSB +: REG_AW], i_inst[FUNC_W-1:0]};
    assign w_addr_raw = i_inst[ADDR_FW-1:0];

    generate
        if (c_IMM_W >= DATA_W) begin : g_imm_trunc
            assign o_imm = w_imm_raw[DATA_W-1:0];
        end else begin : g_imm_sext
            assign o_imm = {{(DATA_W - c_IMM_W){w_imm_raw[c_IMM_W-1]}}, w_imm_raw};
        end

        if (ADDR_FW >= DATA_W) begin : g_addr_trunc
            assign o_addr = w_addr_raw[DATA_W-1:0];
        end else begin : g_addr_sext
            assign o_addr = {{(DATA_W - ADDR_FW){w_addr_raw[ADDR_FW-1]}}, w_addr_raw};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
//  Module      : decode_stage
//  Description : Registered instruction-decode pipeline stage with a
//                valid/ready handshake and a two-entry skid buffer, so
//                in_ready never depends combinationally on out_ready.
//                Optional load-use interlock enabled by the macro
//                DECODE_HAZARD_EN (adds hazard detection and the
//                stall_count output port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int               INST_W  = 16,
    parameter int               OPC_W   = 4,
    parameter int               REG_AW  = 3,
    parameter int               FUNC_W  = 3,
    parameter int               DATA_W  = 8,
    parameter int               ADDR_FW = 7,
    parameter logic [OPC_W-1:0] LOAD_OP = OPC_W'(c_LOAD_OP_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_AW-1:0] rd_addr,
    output logic [REG_AW-1:0] ra_addr,
    output logic [REG_AW-1:0] rb_addr,
    output logic [FUNC_W-1:0] func,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] addr,
    output logic              hazard_stall
`ifdef DECODE_HAZARD_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q,  in_ready_d;
    logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
    logic [OPC_W-1:0]    opcode_q,    opcode_d;
    logic [REG_AW-1:0]   rd_addr_q,   rd_addr_d;
    logic [REG_AW-1:0]   ra_addr_q,   ra_addr_d;
    logic [REG_AW-1:0]   rb_addr_q,   rb_addr_d;
    logic [FUNC_W-1:0]   func_q,      func_d;
    logic [DATA_W-1:0]   imm_q,       imm_d;
    logic [DATA_W-1:0]   addr_q,      addr_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_xfer;
    logic                w_hazard;
    logic                w_load_out;
    logic [INST_W-1:0]   w_mux_inst;
    logic [OPC_W-1:0]    w_dec_opcode;
    logic [REG_AW-1:0]   w_dec_rd;
    logic [REG_AW-1:0]   w_dec_ra;
    logic [REG_AW-1:0]   w_dec_rb;
    logic [FUNC_W-1:0]   w_dec_func;
    logic [DATA_W-1:0]   w_dec_imm;
    logic [DATA_W-1:0]   w_dec_addr;

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = out_valid_q && out_ready;

    // The skid entry is always older than in_inst, so it wins the mux
    assign w_mux_inst = (state_q == S_SKID) ? skid_inst_q : in_inst;

    decode_fields #(
        .INST_W  (INST_W),
        .OPC_W   (OPC_W),
        .REG_AW  (REG_AW),
        .FUNC_W  (FUNC_W),
        .DATA_W  (DATA_W),
        .ADDR_FW (ADDR_FW)
    ) u_decode_fields (
        .i_inst    (w_mux_inst),
        .o_opcode  (w_dec_opcode),
        .o_rd_addr (w_dec_rd),
        .o_ra_addr (w_dec_ra),
        .o_rb_addr (w_dec_rb),
        .o_func    (w_dec_func),
        .o_imm     (w_dec_imm),
        .o_addr    (w_dec_addr)
    );

    // ------------------------------------------------------------------
    // Load-use interlock
    // ------------------------------------------------------------------
`ifdef DECODE_HAZARD_EN
    localparam int c_RA_LSB = ra_lsb(INST_W, OPC_W, REG_AW);
    localparam int c_RB_LSB = rb_lsb(INST_W, OPC_W, REG_AW);

    logic [REG_AW-1:0] w_in_ra;
    logic [REG_AW-1:0] w_in_rb;
    logic [15:0]       stall_count_q, stall_count_d;

    assign w_in_ra = in_inst[c_RA_LSB +: REG_AW];
    assign w_in_rb = in_inst[c_RB_LSB +: REG_AW];

    // Held even while the load transfers out, which guarantees one bubble
    assign w_hazard = out_valid_q && (opcode_q == LOAD_OP) &&
                      ((rd_addr_q == w_in_ra) || (rd_addr_q == w_in_rb));

    // Only a presented instruction that would otherwise be accepted is a stall
    assign hazard_stall = w_hazard && in_valid && (state_q != S_SKID);

    // Saturating count of interlock stall cycles
    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard_stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    logic w_unused_load_op;

    assign w_unused_load_op = ^LOAD_OP;
    assign w_hazard         = 1'b0;
    assign hazard_stall     = 1'b0;
`endif

    // The registered part of in_ready depends only on occupancy
    assign in_ready = in_ready_q && !w_hazard;

    // ------------------------------------------------------------------
    // Next-state and datapath selection
    // ------------------------------------------------------------------
    // Occupancy transitions, skid capture and output-register load enable
    always_comb begin
        state_d     = state_q;
        skid_inst_d = skid_inst_q;
        opcode_d    = opcode_q;
        rd_addr_d   = rd_addr_q;
        ra_addr_d   = ra_addr_q;
        rb_addr_d   = rb_addr_q;
        func_d      = func_q;
        imm_d       = imm_q;
        addr_d      = addr_q;
        w_load_out  = 1'b0;

        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    state_d    = S_FULL;
                    w_load_out = 1'b1;
                end
            end
            S_FULL: begin
                if (w_xfer && w_accept) begin
                    w_load_out = 1'b1;
                end else if (w_xfer) begin
                    state_d = S_EMPTY;
                end else if (w_accept) begin
                    state_d     = S_SKID;
                    skid_inst_d = in_inst;
                end
            end
            S_SKID: begin
                if (w_xfer) begin
                    state_d     = S_FULL;
                    w_load_out  = 1'b1;
                    skid_inst_d = '0;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // Flush drops both entries and any instruction offered this cycle
        if (flush) begin
            state_d     = S_EMPTY;
            skid_inst_d = '0;
            w_load_out  = 1'b0;
        end

        if (w_load_out) begin
            opcode_d  = w_dec_opcode;
            rd_addr_d = w_dec_rd;
            ra_addr_d = w_dec_ra;
            rb_addr_d = w_dec_rb;
            func_d    = w_dec_func;
            imm_d     = w_dec_imm;
            addr_d    = w_dec_addr;
        end

        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_SKID);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // Stage registers; reset discards both entries immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            skid_inst_q <= '0;
            opcode_q    <= '0;
            rd_addr_q   <= '0;
            ra_addr_q   <= '0;
            rb_addr_q   <= '0;
            func_q      <= '0;
            imm_q       <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            skid_inst_q <= skid_inst_d;
            opcode_q    <= opcode_d;
            rd_addr_q   <= rd_addr_d;
            ra_addr_q   <= ra_addr_d;
            rb_addr_q   <= rb_addr_d;
            func_q      <= func_d;
            imm_q       <= imm_d;
            addr_q      <= addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign rd_addr   = rd_addr_q;
    assign ra_addr   = ra_addr_q;
    assign rb_addr   = rb_addr_q;
    assign func      = func_q;
    assign imm       = imm_q;
    assign addr      = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: table of decode
//                vectors, hand-written skid/flush/reset/interlock sequences
//                and a randomized run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [2:0]  rd_addr;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic [2:0]  func;
    logic [7:0]  imm;
    logic [7:0]  addr;
    logic        hazard_stall;
`ifdef DECODE_HAZARD_EN
    logic [15:0] stall_count;
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] dut_f;
    assign dut_f = {opcode, rd_addr, ra_addr, rb_addr, func, imm, addr};

    always #5 clk = ~clk;

    decode_stage #(
        .INST_W  (16),
        .OPC_W   (4),
        .REG_AW  (3),
        .FUNC_W  (3),
        .DATA_W  (8),
        .ADDR_FW (7),
        .LOAD_OP (4'h8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .opcode       (opcode),
        .rd_addr      (rd_addr),
        .ra_addr      (ra_addr),
        .rb_addr      (rb_addr),
        .func         (func),
        .imm          (imm),
        .addr         (addr),
        .hazard_stall (hazard_stall)
`ifdef DECODE_HAZARD_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode using integer arithmetic on the field positions
    function automatic logic [31:0] model_decode(input logic [15:0] w);
        int wi, op, rd, ra, rb, fn, iv, av;
        wi = int'(w);
        op = (wi >> 12) & 15;
        rd = (wi >> 9) & 7;
        ra = (wi >> 6) & 7;
        rb = (wi >> 3) & 7;
        fn = wi & 7;
        iv = rd * 8 + fn;
        if (iv >= 32) iv = iv - 64;
        av = wi & 127;
        if (av >= 64) av = av - 128;
        return {op[3:0], rd[2:0], ra[2:0], rb[2:0], fn[2:0], iv[7:0], av[7:0]};
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_inst   = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] inst;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  fn;
        logic [7:0]  imm;
        logic [7:0]  addr;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] sw[8];
    logic [15:0] q[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r, seen, mcnt;
        bit acc, xf, haz, e_ready, e_valid, e_stall;

        vecs[0] = '{16'h1A53, 4'h1, 3'd5, 3'd1, 3'd2, 3'd3, 8'hEB, 8'hD3};
        vecs[1] = '{16'h0005, 4'h0, 3'd0, 3'd0, 3'd0, 3'd5, 8'h05, 8'h05};
        vecs[2] = '{16'hFFFF, 4'hF, 3'd7, 3'd7, 3'd7, 3'd7, 8'hFF, 8'hFF};
        vecs[3] = '{16'h0000, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00};
        vecs[4] = '{16'h7E38, 4'h7, 3'd7, 3'd0, 3'd7, 3'd0, 8'hF8, 8'h38};
        vecs[5] = '{16'h0440, 4'h0, 3'd2, 3'd1, 3'd0, 3'd0, 8'h10, 8'hC0};
        for (int i = 0; i < 8; i++) sw[i] = 16'h1000 + 16'(i * 16'h0123);

        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_fields", dut_f, 0);
        check("reset_hazard_stall", hazard_stall, 0);
`ifdef DECODE_HAZARD_EN
        check("reset_stall_count", stall_count, 0);
`endif

        // ---------------- table-driven decode ----------------
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            check($sformatf("vec%0d_fields", i), dut_f,
                  {vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].fn, vecs[i].imm, vecs[i].addr});
            @(posedge clk); #1;
        end

        // ---------------- skid buffer stream ----------------
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = sw[0];
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_inst   = sw[1];
        @(negedge clk);
        check("skid_first_valid", out_valid, 1);
        check("skid_first_fields", dut_f, model_decode(sw[0]));
        @(posedge clk); #1;
        in_inst = sw[2];
        @(negedge clk);
        check("skid_in_ready_low", in_ready, 0);
        check("skid_hold_fields", dut_f, model_decode(sw[0]));
        @(posedge clk); #1;
        out_ready = 1'b1;
        s = 2;
        r = 0;
        for (int cyc = 0; cyc < 40 && r < 8; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (xf) begin
                check($sformatf("skid_order%0d", r), dut_f, model_decode(sw[r]));
                r++;
            end
            if (acc) s++;
            @(posedge clk); #1;
            in_valid = (s < 8);
            if (s < 8) in_inst = sw[s];
        end
        check("skid_delivered_count", r, 8);
        @(negedge clk);
        check("skid_drained", out_valid, 0);

        // ---------------- flush while in skid ----------------
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 16'h2111;
        @(posedge clk); #1;
        in_inst = 16'h3222;
        @(posedge clk); #1;
        flush   = 1'b1;
        in_inst = 16'h4333;
        @(negedge clk);
        check("flush_pre_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_ghosts", seen, 0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_inst  = 16'h5444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_next_valid", out_valid, 1);
        check("flush_next_fields", dut_f, model_decode(16'h5444));

        // ---------------- asynchronous reset while in skid ----------------
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 16'h6AAA;
        @(posedge clk); #1;
        in_inst = 16'h7BBB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("areset_pre_valid", out_valid, 1);
        check("areset_pre_in_ready", in_ready, 0);
        #1 reset = 1'b1;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_in_ready", in_ready, 1);
        check("areset_fields", dut_f, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("areset_after_valid", out_valid, 0);

`ifdef DECODE_HAZARD_EN
        // ---------------- load-use interlock ----------------
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 16'h8A00;
        @(posedge clk); #1;
        in_inst = 16'h0140;
        @(negedge clk);
        check("haz_load_valid", out_valid, 1);
        check("haz_load_opcode", opcode, 4'h8);
        check("haz_stall_on", hazard_stall, 1);
        check("haz_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("haz_bubble", out_valid, 0);
        check("haz_stall_off", hazard_stall, 0);
        check("haz_in_ready_back", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("haz_dep_valid", out_valid, 1);
        check("haz_dep_fields", dut_f, model_decode(16'h0140));
        check("haz_stall_count", stall_count, 1);
`endif

        // ---------------- randomized run against queue model ----------------
        do_reset();
        q.delete();
        mcnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_inst   = 16'($urandom);
            if ($urandom_range(0, 2) == 0) in_inst[15:12] = 4'h8;
            @(negedge clk);
            haz = HAZ_EN && (q.size() > 0) && (q[0][15:12] == 4'h8) &&
                  ((q[0][11:9] == in_inst[8:6]) || (q[0][11:9] == in_inst[5:3]));
            e_valid = (q.size() > 0);
            e_ready = (q.size() < 2) && !haz;
            e_stall = haz && in_valid && (q.size() < 2);
            check("rnd_in_ready", in_ready, e_ready);
            check("rnd_out_valid", out_valid, e_valid);
            check("rnd_hazard_stall", hazard_stall, e_stall);
            if (e_valid) check("rnd_fields", dut_f, model_decode(q[0]));
`ifdef DECODE_HAZARD_EN
            check("rnd_stall_count", stall_count, mcnt);
`endif
            if (e_stall && mcnt < 65535) mcnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (e_valid && out_ready) void'(q.pop_front());
                if (in_valid && e_ready) q.push_back(in_inst);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
